gpr_file_mp: RTL

- Parametrised general-purpose register file for the pipelined MIPS core; replaces the fixed 32x32, 2-read single-cycle file.
- Provides NUM_RD combinational read ports and one synchronous write port with three write modes: normal, set-on-sign (SLT result), and link (JAL).
- Adds a per-register pending scoreboard: issue marks a destination busy, writeback clears it. Decode uses the per-port busy flags to stall on RAW hazards.

---
 rtl/gpr_pkg.sv | 37 +++
 rtl/gpr_file_mp_if.sv | 31 +++
 rtl/gpr_scoreboard.sv | 43 ++++
 rtl/gpr_file_mp.sv | 74 +++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared definitions for the gpr_file_mp register file: write-mode encodings,
// the hard-wired zero register index and the write-value formatter used by
// both the storage write path and the read bypass.
package gpr_pkg;

  // Widest data path the formatter handles; callers zero-extend and truncate.
  localparam int unsigned MAX_DW = 64;

  typedef enum logic [1:0] {
    WM_NORM = 2'b00,
    WM_SLT  = 2'b01,
    WM_LINK = 2'b10,
    WM_NONE = 2'b11
  } wr_mode_e;

  localparam int unsigned ZERO_REG = 0;

  // Operands arrive zero-extended to MAX_DW; dw is the real data width so the
  // sign bit for set-on-sign can be located.
  function automatic logic [MAX_DW-1:0] fmt_wdata(input logic [1:0]        mode,
                                                  input logic [MAX_DW-1:0] wr_data,
                                                  input logic [MAX_DW-1:0] pc_plus,
                                                  input int unsigned       dw);
    logic [MAX_DW-1:0] res;
    logic [MAX_DW-1:0] sgn;
    res = '0;
    sgn = wr_data >> (dw - 1);
    case (mode)
      WM_NORM: res = wr_data;
      WM_SLT:  res[0] = sgn[0];
      WM_LINK: res = {pc_plus[MAX_DW-3:0], 2'b00};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gpr_file_mp_if.sv
// Decode/writeback/issue bus of the gpr_file_mp register file.
interface gpr_file_mp_if #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic [1:0]           wr_mode;
  logic [DW-3:0]        pc_plus;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic                 any_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_mode, pc_plus, iss_en, iss_addr,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_mode, pc_plus, iss_en, iss_addr,
    output rd_data, rd_busy, any_busy
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, issue wins on a
// same-register collision. Register 0 is never pending.
module gpr_scoreboard #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned NUM_RD = 2,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set_en,
  input  logic [AW-1:0]        i_set_addr,
  input  logic                 i_clr_en,
  input  logic [AW-1:0]        i_clr_addr,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  input  logic [NUM_RD-1:0]    i_hit,
  output logic [NUM_RD-1:0]    o_busy
);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;

  // Next pending state: clear first so a same-register issue overrides it.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr_en) w_pend_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_pend_nxt[i_set_addr] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  // Pending register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    assign o_busy[k] = r_pend[i_rd_addr[k*AW +: AW]] & ~i_hit[k];
  end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-read-port GPR file with normal/set-on-sign/link writes and a pending
// scoreboard for RAW stall detection. Optional write-to-read bypass is enabled
// by defining GPR_BYPASS_EN. DW must not exceed gpr_pkg::MAX_DW.
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned LINK_REG = NREG - 1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input logic          clk,
  input logic          rst,
  gpr_file_mp_if.slave bus
);

  logic [DW-1:0]     r_regs [NREG];
  logic [AW-1:0]     w_wr_dest;
  logic [MAX_DW-1:0] w_fmt_full;
  logic [DW-1:0]     w_wr_val;
  logic              w_wr_store;
  logic [NUM_RD-1:0] w_hit;

  assign w_wr_dest  = (bus.wr_mode == WM_LINK) ? AW'(LINK_REG) : bus.wr_addr;
  assign w_fmt_full = fmt_wdata(bus.wr_mode, MAX_DW'(bus.wr_data), MAX_DW'(bus.pc_plus), DW);
  assign w_wr_val   = w_fmt_full[DW-1:0];
  assign w_wr_store = bus.wr_en && (bus.wr_mode != WM_NONE) && (w_wr_dest != AW'(ZERO_REG));

  // Register storage: reset clears everything, register 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_store) begin
      r_regs[w_wr_dest] <= w_wr_val;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_stored;

    assign w_addr   = bus.rd_addr[k*AW +: AW];
    assign w_stored = (w_addr == AW'(ZERO_REG)) ? '0 : r_regs[w_addr];

`ifdef GPR_BYPASS_EN
    // A mode-11 writeback still resolves the hazard but carries no data.
    assign w_hit[k] = bus.wr_en && (w_wr_dest == w_addr) && (w_wr_dest != AW'(ZERO_REG));
    assign bus.rd_data[k*DW +: DW] = (w_hit[k] && (bus.wr_mode != WM_NONE)) ? w_wr_val
                                                                            : w_stored;
`else
    assign w_hit[k] = 1'b0;
    assign bus.rd_data[k*DW +: DW] = w_stored;
`endif
  end

  gpr_scoreboard #(
    .NREG   (NREG),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (bus.iss_en),
    .i_set_addr (bus.iss_addr),
    .i_clr_en   (bus.wr_en),
    .i_clr_addr (w_wr_dest),
    .i_rd_addr  (bus.rd_addr),
    .i_hit      (w_hit),
    .o_busy     (bus.rd_busy)
  );

  assign bus.any_busy = |bus.rd_busy;

endmodule
